// File: rtl/fpu_issue_ctrl_pkg.sv
// rtl/fpu_issue_ctrl_pkg.sv - shared float opcodes, FALUop codes and pipe entry type
package fpu_issue_ctrl_pkg;

    localparam logic [6:0] OP_RFSOP = 7'b1010011;
    localparam logic [6:0] OP_FSW   = 7'b0100111;

    localparam logic [4:0] FALU_FADD = 5'b00000;
    localparam logic [4:0] FALU_FSUB = 5'b00001;
    localparam logic [4:0] FALU_FMUL = 5'b00010;
    localparam logic [4:0] FALU_FDIV = 5'b00011;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
    } pipe_entry_t;

    function automatic logic is_fdiv(input logic [4:0] falu_op);
        return falu_op == FALU_FDIV;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_fdiv_timer.sv
// rtl/fpu_issue_ctrl_fdiv_timer.sv - divider occupancy counter and writeback strobe
module fdiv_timer #(
    parameter int DIV_LAT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic [4:0] rem,
    output logic       done
);

    localparam logic [4:0] REM_INIT = 5'(DIV_LAT - 1);

    // rem counts the cycles left before the result cycle; done marks that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            rem  <= 5'd0;
        end else if (start) begin
            busy <= 1'b1;
            rem  <= REM_INIT;
        end else if (busy) begin
            if (rem == 5'd0) begin
                busy <= 1'b0;
            end else begin
                rem <= rem - 5'd1;
            end
        end
    end

    assign done = busy & (rem == 5'd0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - float issue control: scoreboard, hazard stalls, pipe and divider writeback
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 3,
    parameter int DIV_LAT  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_fRs1,
    input  logic [4:0]  in_fRs2,
    input  logic [4:0]  in_fRd,
    input  logic        in_regWrite,
    input  logic        in_save,
    input  logic [4:0]  in_FALUop,
    output logic        issue_valid,
    output logic        issue_div,
    output logic        div_busy,
    output logic        wb_valid,
    output logic [4:0]  wb_fRd,
    output logic        wb_sel,
    output logic [31:0] pending
);

    localparam logic [4:0] PIPE_REM = 5'(PIPE_LAT);

    logic        op_div;
    logic        raw_hazard;
    logic        waw_hazard;
    logic        div_hazard;
    logic        port_hazard;
    logic        stall;
    logic        fire;
    logic [4:0]  div_rem;
    logic        div_wb;
    logic        pipe_wb;
    logic [4:0]  div_rd;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    pipe_entry_t pipe_in;
    pipe_entry_t pipe_q [PIPE_LAT];

    assign op_div = in_regWrite & is_fdiv(in_FALUop);

    // fsw only reads fRs2; non-float instructions read nothing
    assign raw_hazard  = (in_regWrite & pending[in_fRs1])
                       | ((in_regWrite | in_save) & pending[in_fRs2]);
    assign waw_hazard  = in_regWrite & pending[in_fRd];
    assign div_hazard  = op_div & div_busy;
    // a pipe op issued now would land on the same cycle as the divider result
    assign port_hazard = in_regWrite & ~op_div & div_busy & (div_rem == PIPE_REM);

    assign stall       = raw_hazard | waw_hazard | div_hazard | port_hazard;
    assign in_ready    = ~rst & ~stall;
    assign fire        = in_valid & in_ready;
    assign issue_valid = fire & (in_regWrite | in_save);
    assign issue_div   = issue_valid & op_div;

    always_comb begin
        pipe_in           = '0;
        pipe_in.valid     = issue_valid & ~op_div;
        pipe_in.reg_write = in_regWrite;
        pipe_in.rd        = in_fRd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_wb = pipe_q[PIPE_LAT-1].valid & pipe_q[PIPE_LAT-1].reg_write;

    fdiv_timer #(
        .DIV_LAT (DIV_LAT)
    ) u_fdiv_timer (
        .clk   (clk),
        .rst   (rst),
        .start (issue_div),
        .busy  (div_busy),
        .rem   (div_rem),
        .done  (div_wb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_rd <= 5'd0;
        end else if (issue_div) begin
            div_rd <= in_fRd;
        end
    end

    assign wb_valid = pipe_wb | div_wb;
    assign wb_sel   = div_wb & ~pipe_wb;
    assign wb_fRd   = pipe_wb ? pipe_q[PIPE_LAT-1].rd :
                      div_wb  ? div_rd : 5'd0;

    // set and clear never hit the same bit: WAW stalls any issue to a pending rd
    assign set_mask = (issue_valid & in_regWrite) ? (32'd1 << in_fRd) : 32'd0;
    assign clr_mask = wb_valid ? (32'd1 << wb_fRd) : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 32'd0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(pipe_wb && div_wb));

endmodule
